// File: rtl/fifo_rd_ctrl_pkg.sv
// rtl/fifo_rd_ctrl_pkg.sv - shared pointer helpers for the async FIFO controllers
package fifo_rd_ctrl_pkg;

  localparam int PTR_MAX_W = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_gray2bin.sv
// rtl/fifo_rd_ctrl_gray2bin.sv - combinational Gray to binary conversion
module fifo_rd_ctrl_gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - async FIFO read-domain controller with FWFT output register
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int ASIZE     = 4,
  parameter int DSIZE     = 8,
  parameter int AE_THRESH = 2
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [ASIZE:0]   s_wptr,
  output logic [ASIZE:0]   rptr,
  output logic [ASIZE-1:0] raddr,
  output logic             ren,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic [DSIZE-1:0] rdata,
  output logic             rvalid,
  input  logic             rready,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   rcount,
  output logic             rerr
);

  localparam int PW = ASIZE + 1;
  localparam logic [PW-1:0] DEPTH = PW'(2 ** ASIZE);
  localparam logic [PW-1:0] AE_T  = PW'(AE_THRESH);

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbinnext;
  logic [PW-1:0] rgraynext;
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] occ_next;

  fifo_rd_ctrl_gray2bin #(.W(PW)) u_wptr_g2b (
    .gray (s_wptr),
    .bin  (wbin_s)
  );

  // rempty is registered, so the read strobe never loops back on itself.
  assign ren       = !rempty && (!rvalid || rready);
  assign rbinnext  = rbin + PW'(ren);
  assign rgraynext = PW'(bin2gray(PTR_MAX_W'(rbinnext)));
  assign occ_next  = wbin_s - rbinnext;
  assign raddr     = rbin[ASIZE-1:0];

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      rcount        <= '0;
      ralmost_empty <= 1'b1;
      rerr          <= 1'b0;
    end else begin
      rbin          <= rbinnext;
      rptr          <= rgraynext;
      rempty        <= (rgraynext == s_wptr);
      rcount        <= occ_next;
      ralmost_empty <= (occ_next <= AE_T);
      if (occ_next > DEPTH) rerr <= 1'b1;
    end
  end

  // A load and a transfer in the same cycle keep rvalid high for back-to-back words.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else if (ren) begin
      rdata  <= mem_rdata;
      rvalid <= 1'b1;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - randomized self-checking bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic [4:0] s_wptr;
  logic [4:0] rptr;
  logic [3:0] raddr;
  logic       ren;
  logic [7:0] mem_rdata;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready;
  logic       rempty;
  logic       ralmost_empty;
  logic [4:0] rcount;
  logic       rerr;

  logic [7:0] mem [16];

  int tests = 0;
  int fails = 0;

  // Reference model: words written but not yet fetched, plus the output register.
  logic [7:0] memq [$];
  int         wcount   = 0;
  int         rd_total = 0;
  int         visible  = 0;
  bit         ov       = 0;
  logic [7:0] od       = '0;
  int         ren_cnt  = 0;
  int         xfer_cnt = 0;
  int         max_rcount = 0;
  logic [4:0] prev_rptr = '0;

  always #5 rclk = ~rclk;

  assign mem_rdata = mem[raddr];

  fifo_rd_ctrl #(.ASIZE(4), .DSIZE(8), .AE_THRESH(2)) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .s_wptr        (s_wptr),
    .rptr          (rptr),
    .raddr         (raddr),
    .ren           (ren),
    .mem_rdata     (mem_rdata),
    .rdata         (rdata),
    .rvalid        (rvalid),
    .rready        (rready),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rcount        (rcount),
    .rerr          (rerr)
  );

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    memq.delete();
    wcount = 0; rd_total = 0; visible = 0; ov = 0; od = '0; prev_rptr = '0;
  endtask

  task automatic check_outputs();
    chk("rvalid", rvalid, ov);
    chk("rdata", rdata, od);
    chk("rempty", rempty, visible == 0);
    chk("rcount", rcount, visible);
    chk("ralmost_empty", ralmost_empty, visible <= 2);
    chk("rptr", rptr, gray5(rd_total));
    chk("raddr", raddr, rd_total % 16);
    chk("rerr", rerr, 1'b0);
    chk("gray_step", $countones(prev_rptr ^ rptr) <= 1, 1'b1);
    prev_rptr = rptr;
    if (int'(rcount) > max_rcount) max_rcount = int'(rcount);
  endtask

  // One rclk cycle starting just after a falling edge.
  task automatic cycle(input bit push, input bit rdy);
    logic [7:0] d;
    bit ren_e;
    rready = rdy;
    if (push && memq.size() < 16) begin
      d = 8'($urandom);
      mem[wcount % 16] = d;
      memq.push_back(d);
      wcount++;
      s_wptr = gray5(wcount);
    end
    #1;
    ren_e = (visible != 0) && (!ov || rdy);
    chk("ren", ren, ren_e);
    if (ren) ren_cnt++;
    if (rvalid && rdy) xfer_cnt++;
    @(posedge rclk);
    if (ren_e) begin
      od = memq.pop_front();
      ov = 1;
      rd_total++;
    end else if (ov && rdy) begin
      ov = 0;
    end
    visible = wcount - rd_total;
    @(negedge rclk);
    check_outputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rrst_n = 1'b0;
    rready = 1'b1;
    s_wptr = 5'b00110;

    // Reset held with a non-zero write pointer
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      chk("rst_rempty", rempty, 1'b1);
      chk("rst_rvalid", rvalid, 1'b0);
      chk("rst_rptr", rptr, 5'd0);
      chk("rst_rcount", rcount, 5'd0);
      chk("rst_ae", ralmost_empty, 1'b1);
      chk("rst_rerr", rerr, 1'b0);
      chk("rst_ren", ren, 1'b0);
    end
    s_wptr = 5'd0;
    @(negedge rclk);
    rrst_n = 1'b1;
    model_reset();

    // Single word with latency check
    cycle(1, 1);
    chk("single_rempty_fall", rempty, 1'b0);
    cycle(0, 1);
    chk("single_rvalid", rvalid, 1'b1);
    chk("single_rptr", rptr, 5'b00001);
    chk("single_rempty_again", rempty, 1'b1);
    cycle(0, 1);

    // Back-pressure: three words, consumer stalled
    ren_cnt = 0;
    for (int i = 0; i < 3; i++) cycle(1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0);
    chk("bp_ren_count", ren_cnt, 1);
    chk("bp_rcount", rcount, 5'd2);
    xfer_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rvalid_before_xfer", rvalid, 1'b1);
      cycle(0, 1);
    end
    chk("bp_xfer_count", xfer_cnt, 3);
    chk("bp_drained", rvalid, 1'b0);

    // Fill to full depth, then drain through almost-empty
    max_rcount = 0;
    for (int i = 0; i < 20; i++) cycle(1, 0);
    chk("full_peak", max_rcount, 16);
    for (int i = 0; i < 20; i++) cycle(0, 1);

    // Random traffic, well beyond several pointer wraps
    for (int i = 0; i < 400; i++) cycle(($urandom % 3) != 0, ($urandom % 4) != 0);
    for (int i = 0; i < 20; i++) cycle(0, 1);
    chk("wrap_reached", rd_total > 40, 1'b1);

    // Pointer inconsistency: write pointer implies 20 words
    rready = 1'b0;
    s_wptr = gray5(rd_total + 20);
    @(negedge rclk);
    chk("err_set", rerr, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      chk("err_sticky", rerr, 1'b1);
    end
    rready = 1'b1;
    @(negedge rclk);
    #2;
    rrst_n = 1'b0;
    #1;
    chk("midrst_rvalid", rvalid, 1'b0);
    chk("midrst_rerr", rerr, 1'b0);
    chk("midrst_rptr", rptr, 5'd0);
    chk("midrst_raddr", raddr, 4'd0);
    chk("midrst_rempty", rempty, 1'b1);
    s_wptr = 5'd0;
    @(negedge rclk);
    rrst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 30; i++) cycle(($urandom % 2) != 0, ($urandom % 2) != 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
